stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Centisecond stopwatch core sitting directly downstream of the 100 Hz tick generator. Counts single-cycle `tick` pulses (one per 10 ms at 100 MHz `clk`) into a BCD MM:SS.cc value under start/stop, clear and lap control. Its outputs feed the seven-segment display driver. All control inputs are single-cycle, already-debounced pulses synchronous to `clk`.

## Interface
- `MAX_MIN`, default 59: highest minute value before wrap; legal range 1–59.
- `clk`  input  1  system clock, 100 MHz.
- `reset`  input  1  asynchronous, active-low reset.
- `tick`  input  1  one-cycle pulse every 10 ms; counting enable.
- `start_stop`  input  1  one-cycle pulse; toggles run/pause.
- `clear`  input  1  one-cycle pulse; zeroes the count when not running.
- `lap`  input  1  one-cycle pulse; toggles display hold.
- `digits`  output  24  BCD display value {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, 4 bits each, MSB first.
- `running`  output  1  high in RUN.
- `lap_hold`  output  1  high while the display is frozen.
- `wrap`  output  1  one-cycle pulse when the count rolls over from MAX_MIN:59.99 to 00:00.00.

## Operation
- States: IDLE, RUN, PAUSE. Reset enters IDLE, and the live count and display register reset to 0.
- IDLE: `start_stop` -> RUN.
- RUN: `start_stop` -> PAUSE. `clear` is ignored.
- PAUSE: `start_stop` -> RUN. `clear` -> IDLE with the count zeroed.
- IDLE with `clear`: stays in IDLE, and the count is zeroed again.
- Counting happens only in RUN, on each `tick`:
  - cs_o increments 0–9 and carries into cs_t.
  - cs_t runs 0–9 and carries into sec_o.
  - sec_o runs 0–9 and carries into sec_t.
  - sec_t runs 0–5 and carries into min_o.
  - min_o/min_t form BCD minutes 0..MAX_MIN.
  - At MAX_MIN:59.99, a tick sets the count to all zeros and pulses `wrap`. Counting continues.
- Every digit is always a legal BCD value. No nibble ever holds a value above 9.
- `digits` shows the live count, or the held copy while `lap_hold` = 1.
- Simultaneous events:
  - `clear` and `start_stop` together in IDLE or PAUSE: clear wins, and the state is IDLE.
  - `tick` and `start_stop` together in RUN: the tick is counted and the state becomes PAUSE.
  - `tick` and `start_stop` together in PAUSE: the state becomes RUN and the tick is not counted.
- `reset` asserted mid-count: all state is discarded immediately.

## Timing
- All outputs are registered.
- The `digits` and `wrap` update from a `tick` appear one clock after the cycle in which `tick` is high.
- `running` changes one clock after `start_stop` or `clear`.
- Reset values: `digits`=24'h0, `running`=0, `lap_hold`=0, `wrap`=0.
- Between ticks the count is stable. `wrap` is high for exactly one cycle.

## Configuration
- The lap feature is compiled in by the macro `STOPWATCH_LAP_EN`.
- When `STOPWATCH_LAP_EN` is defined:
  - `lap` in RUN with `lap_hold`=0 captures the live count (including any same-cycle tick increment) into the hold register and sets `lap_hold`.
  - `lap` with `lap_hold`=1 releases the hold.
  - `lap` in IDLE or PAUSE releases the hold, or does nothing if no hold is active.
  - `clear` releases the hold.
  - The live count keeps running while the display is held.
- Without `STOPWATCH_LAP_EN`:
  - No hold register is built.
  - `lap` is ignored.
  - `lap_hold` is tied to 0.
  - `digits` always shows the live count.

## Structure
- Shared package `stopwatch_pkg` contains:
  - the state enum (IDLE/RUN/PAUSE);
  - a 4-bit BCD digit typedef;
  - constants CS_ONES_MAX=9, SEC_TENS_MAX=5 and the default MAX_MIN=59.
- Sub-module `bcd_digit_counter` (parameter `LIMIT`; inputs `inc`, `clr`; outputs `digit` and a combinational `carry` = inc && digit==LIMIT) is used for the cs and sec digits. The minutes pair is handled locally to apply MAX_MIN.

## Test plan
- Reset, then `start_stop`, then 150 ticks -> `digits`=00:01.50 and `running`=1.
- Run to 00:59.99, then one tick -> 01:00.00 one cycle later.
- Preload to MAX_MIN:59.99 by driving ticks, then one more tick -> `digits`=00:00.00 and a single-cycle `wrap`.
- `tick` and `start_stop` together at 00:00.05 in RUN -> 00:00.06 and PAUSE. Then `clear` -> IDLE and 00:00.00. `clear` issued during RUN -> no effect.
- With `STOPWATCH_LAP_EN`: lap at 00:02.00, then 30 ticks -> `digits` holds 00:02.00 with `lap_hold`=1. Second lap -> 00:02.30.
- Assert `reset` low between ticks mid-run -> all outputs 0 immediately, state IDLE; subsequent ticks are not counted until `start_stop`.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned DIGITS_W        = 6 * DIGIT_W;
  localparam int unsigned CS_ONES_MAX     = 9;
  localparam int unsigned SEC_TENS_MAX    = 5;
  localparam int unsigned DEFAULT_MAX_MIN = 59;

  typedef logic [DIGIT_W-1:0] bcd_t;

  // Next value of one BCD digit that wraps to zero after reaching limit.
  function automatic bcd_t bcd_next(input bcd_t d, input logic inc, input logic clr,
                                    input bcd_t limit);
    if (clr) return '0;
    if (!inc) return d;
    return (d == limit) ? '0 : d + bcd_t'(1);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counting 0..LIMIT with a combinational carry-out.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned LIMIT = CS_ONES_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output bcd_t digit,
  output logic carry
);

  assign carry = inc && (digit == bcd_t'(LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) digit <= '0;
    else        digit <= bcd_next(digit, inc, clr, bcd_t'(LIMIT));
  end

endmodule

// File: rtl/stopwatch_counter.sv
// BCD MM:SS.cc stopwatch with run/pause/clear control.
// Display hold (lap) is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN = DEFAULT_MAX_MIN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                lap,
  output logic [DIGITS_W-1:0] digits,
  output logic                running,
  output logic                lap_hold,
  output logic                wrap
);

  localparam bcd_t MIN_T_MAX = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MIN_O_MAX = bcd_t'(MAX_MIN % 10);

  state_t state;
  logic   cnt_inc, cnt_clr;
  bcd_t   cs_o, cs_t, sec_o, sec_t, min_o, min_t;
  logic   cs_o_cy, cs_t_cy, sec_o_cy, sec_t_cy;
  bcd_t   min_o_nxt, min_t_nxt;
  logic   wrap_nxt, hold_nxt;
  logic [DIGITS_W-1:0] live_nxt;

  assign cnt_inc = tick && (state == RUN);
  assign cnt_clr = clear && (state != RUN);

  bcd_digit_counter #(.LIMIT(CS_ONES_MAX)) u_cs_o (
    .clk(clk), .reset(reset), .inc(cnt_inc), .clr(cnt_clr), .digit(cs_o), .carry(cs_o_cy)
  );
  bcd_digit_counter #(.LIMIT(CS_ONES_MAX)) u_cs_t (
    .clk(clk), .reset(reset), .inc(cs_o_cy), .clr(cnt_clr), .digit(cs_t), .carry(cs_t_cy)
  );
  bcd_digit_counter #(.LIMIT(CS_ONES_MAX)) u_sec_o (
    .clk(clk), .reset(reset), .inc(cs_t_cy), .clr(cnt_clr), .digit(sec_o), .carry(sec_o_cy)
  );
  bcd_digit_counter #(.LIMIT(SEC_TENS_MAX)) u_sec_t (
    .clk(clk), .reset(reset), .inc(sec_o_cy), .clr(cnt_clr), .digit(sec_t), .carry(sec_t_cy)
  );

  // Minutes pair rolls over at MAX_MIN rather than at 99.
  always_comb begin
    min_t_nxt = min_t;
    min_o_nxt = min_o;
    wrap_nxt  = 1'b0;
    if (cnt_clr) begin
      min_t_nxt = '0;
      min_o_nxt = '0;
    end else if (sec_t_cy) begin
      if (min_t == MIN_T_MAX && min_o == MIN_O_MAX) begin
        min_t_nxt = '0;
        min_o_nxt = '0;
        wrap_nxt  = 1'b1;
      end else if (min_o == bcd_t'(CS_ONES_MAX)) begin
        min_o_nxt = '0;
        min_t_nxt = min_t + bcd_t'(1);
      end else begin
        min_o_nxt = min_o + bcd_t'(1);
      end
    end
  end

  // Count as it will be after this edge; feeds the display register and lap capture.
  assign live_nxt = {min_t_nxt, min_o_nxt,
                     bcd_next(sec_t, sec_o_cy, cnt_clr, bcd_t'(SEC_TENS_MAX)),
                     bcd_next(sec_o, cs_t_cy, cnt_clr, bcd_t'(CS_ONES_MAX)),
                     bcd_next(cs_t, cs_o_cy, cnt_clr, bcd_t'(CS_ONES_MAX)),
                     bcd_next(cs_o, cnt_inc, cnt_clr, bcd_t'(CS_ONES_MAX))};

`ifdef STOPWATCH_LAP_EN
  always_comb begin
    hold_nxt = lap_hold;
    if (clear)                    hold_nxt = 1'b0;
    else if (lap && lap_hold)     hold_nxt = 1'b0;
    else if (lap && state == RUN) hold_nxt = 1'b1;
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign hold_nxt   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      running  <= 1'b0;
      lap_hold <= 1'b0;
      wrap     <= 1'b0;
      digits   <= '0;
      min_t    <= '0;
      min_o    <= '0;
    end else begin
      min_t    <= min_t_nxt;
      min_o    <= min_o_nxt;
      wrap     <= wrap_nxt;
      lap_hold <= hold_nxt;
      // While held, the display register itself is the frozen lap copy.
      if (!(hold_nxt && lap_hold)) digits <= live_nxt;
      case (state)
        IDLE: if (start_stop && !clear) begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: if (start_stop) begin
          state   <= PAUSE;
          running <= 1'b0;
        end
        PAUSE: if (clear) begin
          state <= IDLE;
        end else if (start_stop) begin
          state   <= RUN;
          running <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench: centisecond-integer reference model plus directed literal checks.
module tb_stopwatch_counter;

  localparam int unsigned MAXM   = 2;
  localparam int          PERIOD = (MAXM + 1) * 6000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [23:0] digits;
  logic        running, lap_hold, wrap;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: count in plain centiseconds, state 0=idle 1=run 2=pause.
  int m_cnt = 0, m_st = 0, m_held_cnt = 0;
  bit m_held = 1'b0, m_wrap = 1'b0;

  stopwatch_counter #(.MAX_MIN(MAXM)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear),
    .lap(lap), .digits(digits), .running(running), .lap_hold(lap_hold), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int c);
    int m, s, cs;
    m  = c / 6000;
    s  = (c / 100) % 60;
    cs = c % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("digits", 32'(digits), 32'(to_bcd(m_held ? m_held_cnt : m_cnt)));
    check("running", 32'(running), 32'(m_st == 1));
    check("lap_hold", 32'(lap_hold), 32'(m_held));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic model_reset();
    m_cnt = 0; m_st = 0; m_held = 1'b0; m_held_cnt = 0; m_wrap = 1'b0;
  endtask

  task automatic model_update(input logic t, input logic ss, input logic cl, input logic lp);
    int nc;
    bit w;
    nc = m_cnt;
    w  = 1'b0;
    if (m_st == 1 && t) begin
      nc++;
      if (nc == PERIOD) begin nc = 0; w = 1'b1; end
    end
    if (m_st != 1 && cl) nc = 0;
`ifdef STOPWATCH_LAP_EN
    if (cl) m_held = 1'b0;
    else if (lp) begin
      if (m_held) m_held = 1'b0;
      else if (m_st == 1) begin m_held = 1'b1; m_held_cnt = nc; end
    end
`else
    if (lp) m_held = 1'b0;
`endif
    case (m_st)
      0: m_st = (ss && !cl) ? 1 : 0;
      1: if (ss) m_st = 2;
      2: if (cl) m_st = 0; else if (ss) m_st = 1;
      default: m_st = 0;
    endcase
    m_cnt  = nc;
    m_wrap = w;
  endtask

  task automatic step(input logic t, input logic ss, input logic cl, input logic lp);
    tick = t; start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    model_update(t, ss, cl, lp);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    model_reset();
    compare_all();
    check("reset_digits", 32'(digits), 32'h0);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_no_count", 32'(digits), 32'h0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(150);
    check("t_150", 32'(digits), 32'h000150);
    check("t_150_running", 32'(running), 32'h1);

    run_ticks(5999 - 150);
    check("t_5999", 32'(digits), 32'h005999);
    run_ticks(1);
    check("t_minute", 32'(digits), 32'h010000);

    run_ticks(PERIOD - 1 - 6000);
    check("t_max", 32'(digits), 32'h025999);
    check("t_max_nowrap", 32'(wrap), 32'h0);
    run_ticks(1);
    check("wrap_digits", 32'(digits), 32'h0);
    check("wrap_pulse", 32'(wrap), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_single", 32'(wrap), 32'h0);

    run_ticks(5);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("tick_ss_digits", 32'(digits), 32'h000006);
    check("tick_ss_paused", 32'(running), 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("pause_clear", 32'(digits), 32'h0);
    check("pause_clear_idle", 32'(running), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("run_clear_ignored", 32'(digits), 32'h000003);
    check("run_clear_running", 32'(running), 32'h1);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(200);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks(30);
`ifdef STOPWATCH_LAP_EN
    check("lap_frozen", 32'(digits), 32'h000200);
    check("lap_hold_set", 32'(lap_hold), 32'h1);
`else
    check("nolap_live", 32'(digits), 32'h000230);
    check("nolap_hold", 32'(lap_hold), 32'h0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_release", 32'(digits), 32'h000230);
    check("lap_hold_clr", 32'(lap_hold), 32'h0);

    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 24) == 0));
    end

    if (m_st != 1) step(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(7);
    check("pre_reset_running", 32'(running), 32'h1);
    reset = 1'b0;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    #1;
    check("async_digits", 32'(digits), 32'h0);
    check("async_running", 32'(running), 32'h0);
    check("async_lap_hold", 32'(lap_hold), 32'h0);
    check("async_wrap", 32'(wrap), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    run_ticks(10);
    check("post_reset_idle", 32'(digits), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(1);
    check("post_reset_count", 32'(digits), 32'h000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
